// File: rtl/vga_bus_periph.sv
// vga_bus_periph: bus-mapped VGA peripheral with a tile framebuffer.
//   A 7-register window at BASE_ADDR holds control, background colour,
//   the cursor, the framebuffer data port, status and a frame counter.
//   The VGA timing is generated from clk with a PIX_DIV pixel divider.
//   The display path is two pixel ticks deep: a tile fetch, then colour select.
// Ports:
//   clk, rstN           single clock, async active-low reset
//   busWe/busAddr/busDin bus write strobe, address and write data
//   busDout             registered read data (0 outside the window)
//   busSel              combinational window decode
//   vgaColor/hSync/vSync VGA outputs, mutually aligned
//   vblankIrq           irqPending & CTRL.irqEn
module vga_bus_periph #(
  parameter int unsigned ADDR_W    = 6,
  parameter int unsigned DATA_W    = 8,
  parameter int unsigned BASE_ADDR = 13,
  parameter int unsigned COLOR_W   = 8,
  parameter int unsigned H_ACTIVE  = 640,
  parameter int unsigned H_FP      = 16,
  parameter int unsigned H_SYNC    = 96,
  parameter int unsigned H_BP      = 48,
  parameter int unsigned V_ACTIVE  = 480,
  parameter int unsigned V_FP      = 10,
  parameter int unsigned V_SYNC    = 2,
  parameter int unsigned V_BP      = 33,
  parameter int unsigned PIX_DIV   = 2,
  parameter int unsigned FB_W      = 40,
  parameter int unsigned FB_H      = 30,
  parameter bit          SYNC_POL  = 1'b0
) (
  input  logic               clk,
  input  logic               rstN,
  input  logic               busWe,
  input  logic [ADDR_W-1:0]  busAddr,
  input  logic [DATA_W-1:0]  busDin,
  output logic [DATA_W-1:0]  busDout,
  output logic               busSel,
  output logic [COLOR_W-1:0] vgaColor,
  output logic               hSync,
  output logic               vSync,
  output logic               vblankIrq
);
  localparam int unsigned HTOT   = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int unsigned VTOT   = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int unsigned HW     = $clog2(HTOT);
  localparam int unsigned VW     = $clog2(VTOT);
  localparam int unsigned DW     = (PIX_DIV > 1) ? $clog2(PIX_DIV) : 1;
  localparam int unsigned XW     = (FB_W > 1) ? $clog2(FB_W) : 1;
  localparam int unsigned YW     = (FB_H > 1) ? $clog2(FB_H) : 1;
  localparam int unsigned FBN    = FB_W * FB_H;
  localparam int unsigned AW     = (FBN > 1) ? $clog2(FBN) : 1;
  localparam int unsigned TILE_W = H_ACTIVE / FB_W;
  localparam int unsigned TILE_H = V_ACTIVE / FB_H;

  // ---------------- timing ----------------
  logic [DW-1:0] div_q, div_d;
  logic [HW-1:0] hCnt_q, hCnt_d;
  logic [VW-1:0] vCnt_q, vCnt_d;
  logic [31:0]   hc, vc;
  logic          tick, active, hs_on, vs_on, vblank, vb_evt;

  assign hc     = 32'(hCnt_q);
  assign vc     = 32'(vCnt_q);
  assign tick   = (32'(div_q) == PIX_DIV - 1);
  assign active = (hc < H_ACTIVE) && (vc < V_ACTIVE);
  assign hs_on  = (hc >= H_ACTIVE + H_FP) && (hc < H_ACTIVE + H_FP + H_SYNC);
  assign vs_on  = (vc >= V_ACTIVE + V_FP) && (vc < V_ACTIVE + V_FP + V_SYNC);
  assign vblank = (vc >= V_ACTIVE);
  // fires on the tick that moves the counters onto (hCnt=0, vCnt=V_ACTIVE)
  assign vb_evt = tick && (hc == HTOT - 1) && (vc == V_ACTIVE - 1);

  always_comb begin
    div_d  = tick ? '0 : div_q + 1'b1;
    hCnt_d = hCnt_q;
    vCnt_d = vCnt_q;
    if (tick) begin
      if (hc == HTOT - 1) begin
        hCnt_d = '0;
        vCnt_d = (vc == VTOT - 1) ? '0 : vCnt_q + 1'b1;
      end else begin
        hCnt_d = hCnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      div_q  <= '0;
      hCnt_q <= '0;
      vCnt_q <= '0;
    end else begin
      div_q  <= div_d;
      hCnt_q <= hCnt_d;
      vCnt_q <= vCnt_d;
    end
  end

  // ---------------- register window ----------------
  logic [31:0]       addr_ext;
  logic [2:0]        off;
  logic              wr;
  logic [2:0]        ctrl_q, ctrl_d;   // {irqEn, autoInc, en}
  logic [DATA_W-1:0] bg_q, bg_d;
  logic [XW-1:0]     curx_q, curx_d;
  logic [YW-1:0]     cury_q, cury_d;
  logic              irq_q, irq_d;
  logic [7:0]        frame_q, frame_d;
  logic [DATA_W-1:0] rd_q, rd_d;
  logic [AW-1:0]     cur_addr, disp_addr;
  logic [DATA_W-1:0] fb [FBN];

  assign addr_ext = 32'(busAddr);
  assign busSel   = (addr_ext >= BASE_ADDR) && (addr_ext <= BASE_ADDR + 6);
  assign off      = 3'(addr_ext - BASE_ADDR);
  assign wr       = busWe && busSel;
  assign cur_addr = AW'(32'(cury_q) * FB_W + 32'(curx_q));

  always_comb begin
    ctrl_d  = ctrl_q;
    bg_d    = bg_q;
    curx_d  = curx_q;
    cury_d  = cury_q;
    irq_d   = irq_q;
    frame_d = frame_q;
    if (vb_evt) frame_d = frame_q + 8'd1;
    if (wr) begin
      case (off)
        3'd0: ctrl_d = busDin[2:0];
        3'd1: bg_d   = busDin;
        3'd2: curx_d = (32'(busDin) >= FB_W) ? XW'(FB_W - 1) : XW'(busDin);
        3'd3: cury_d = (32'(busDin) >= FB_H) ? YW'(FB_H - 1) : YW'(busDin);
        3'd4: if (ctrl_q[1]) begin
          if (32'(curx_q) == FB_W - 1) begin
            curx_d = '0;
            cury_d = (32'(cury_q) == FB_H - 1) ? '0 : cury_q + 1'b1;
          end else begin
            curx_d = curx_q + 1'b1;
          end
        end
        3'd5: if (busDin[2]) irq_d = 1'b0;
        3'd6: frame_d = '0;              // software write beats the increment
        default: ;
      endcase
    end
    if (vb_evt) irq_d = 1'b1;            // hardware set beats software clear

    rd_d = '0;
    if (busSel) begin
      case (off)
        3'd0: rd_d[2:0] = ctrl_q;
        3'd1: rd_d      = bg_q;
        3'd2: rd_d      = DATA_W'(curx_q);
        3'd3: rd_d      = DATA_W'(cury_q);
        3'd4: rd_d      = fb[cur_addr];
        3'd5: rd_d[2:0] = {irq_q, hc < H_ACTIVE, vblank};
        3'd6: rd_d      = DATA_W'(frame_q);
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      ctrl_q  <= '0;
      bg_q    <= '0;
      curx_q  <= '0;
      cury_q  <= '0;
      irq_q   <= 1'b0;
      frame_q <= '0;
      rd_q    <= '0;
    end else begin
      ctrl_q  <= ctrl_d;
      bg_q    <= bg_d;
      curx_q  <= curx_d;
      cury_q  <= cury_d;
      irq_q   <= irq_d;
      frame_q <= frame_d;
      rd_q    <= rd_d;
    end
  end

  // framebuffer contents survive reset
  always_ff @(posedge clk) begin
    if (wr && off == 3'd4) fb[cur_addr] <= busDin;
  end

  // ---------------- display pipeline ----------------
  logic [DATA_W-1:0]  cell_q;
  logic               act1_q;
  logic [2:1]         hs_q, vs_q;      // sync "asserted" flags, two ticks deep
  logic [COLOR_W-1:0] color_q, color_d;

  assign disp_addr = active ? AW'((vc / TILE_H) * FB_W + hc / TILE_W) : '0;

  always_comb begin
    color_d = '0;
    if (act1_q && ctrl_q[0])
      color_d = (cell_q != '0) ? cell_q[COLOR_W-1:0] : bg_q[COLOR_W-1:0];
  end

  // the fetch reads before this edge's CPU write, so the display sees old data
  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      cell_q  <= '0;
      act1_q  <= 1'b0;
      hs_q    <= '0;
      vs_q    <= '0;
      color_q <= '0;
    end else if (tick) begin
      cell_q  <= fb[disp_addr];
      act1_q  <= active;
      hs_q    <= {hs_q[1], hs_on};
      vs_q    <= {vs_q[1], vs_on};
      color_q <= color_d;
    end
  end

  assign busDout   = rd_q;
  assign vgaColor  = color_q;
  assign hSync     = hs_q[2] ? SYNC_POL : ~SYNC_POL;
  assign vSync     = vs_q[2] ? SYNC_POL : ~SYNC_POL;
  assign vblankIrq = irq_q & ctrl_q[2];
endmodule

// File: tb/tb_vga_bus_periph.sv
`timescale 1ns/1ps
module tb_vga_bus_periph;
  localparam int HA = 16, HF = 2, HS = 3, HB = 3;
  localparam int VA = 8,  VF = 1, VS = 2, VB = 1;
  localparam int PD = 2, FW = 4, FH = 4, BASE = 13;
  localparam int HTOT = HA + HF + HS + HB;          // 24
  localparam int VTOT = VA + VF + VS + VB;          // 12
  localparam int FRAME_CLK = HTOT * VTOT * PD;      // 576
  localparam int TW = HA / FW, TH = VA / FH;        // 4 x 2 pixel tiles
  localparam bit SP = 1'b0;

  logic       clk = 0, rstN = 1, busWe = 0;
  logic [5:0] busAddr = 0;
  logic [7:0] busDin = 0;
  logic [7:0] busDout, vgaColor;
  logic       busSel, hSync, vSync, vblankIrq;

  vga_bus_periph #(.ADDR_W(6), .DATA_W(8), .BASE_ADDR(BASE), .COLOR_W(8),
    .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
    .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB),
    .PIX_DIV(PD), .FB_W(FW), .FB_H(FH), .SYNC_POL(SP)) dut (
    .clk(clk), .rstN(rstN), .busWe(busWe), .busAddr(busAddr), .busDin(busDin),
    .busDout(busDout), .busSel(busSel), .vgaColor(vgaColor),
    .hSync(hSync), .vSync(vSync), .vblankIrq(vblankIrq));

  always #5 clk = ~clk;

  int checks = 0, failures = 0, cyc = 0;
  always @(posedge clk) cyc++;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d t=%0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // Position is derived from the number of clocks since reset; the display
  // shows the pixel from two ticks ago.
  int       nclk, m_cx, m_cy, e1_pos;
  bit [2:0] m_ctrl;
  bit [7:0] m_bg, m_frame, m_dout, m_color, e1_cell;
  bit [7:0] m_fb [FW*FH];
  bit       m_irq, m_hs, m_vs, e1_v, e1_act;

  function automatic bit in_win(int a);
    return a >= BASE && a <= BASE + 6;
  endfunction

  function automatic bit [7:0] m_read(int off, int p);
    case (off)
      0: return {5'b0, m_ctrl};
      1: return m_bg;
      2: return 8'(m_cx);
      3: return 8'(m_cy);
      4: return m_fb[m_cy*FW + m_cx];
      5: return {5'b0, m_irq, (p % HTOT) < HA, (p / HTOT) >= VA};
      6: return m_frame;
      default: return 8'd0;
    endcase
  endfunction

  always @(posedge clk or negedge rstN) begin
    int  p, off;
    bit  tick, sel, evt, clr, fwr;
    if (!rstN) begin
      nclk = 0; m_cx = 0; m_cy = 0; m_ctrl = 0; m_bg = 0; m_frame = 0;
      m_dout = 0; m_color = 0; m_irq = 0; m_hs = 0; m_vs = 0; e1_v = 0;
      e1_pos = 0; e1_cell = 0; e1_act = 0;
    end else begin
      p = (nclk / PD) % (HTOT * VTOT);
      nclk++;
      tick = (nclk % PD) == 0;
      sel = in_win(int'(busAddr));
      off = int'(busAddr) - BASE;
      m_dout = sel ? m_read(off, p) : 8'd0;
      evt = tick && (p == VA * HTOT - 1);
      if (tick) begin
        if (e1_v) begin
          m_color = (e1_act && m_ctrl[0]) ? ((e1_cell != 0) ? e1_cell : m_bg) : 8'd0;
          m_hs = (e1_pos % HTOT) >= HA + HF && (e1_pos % HTOT) < HA + HF + HS;
          m_vs = (e1_pos / HTOT) >= VA + VF && (e1_pos / HTOT) < VA + VF + VS;
        end
        e1_v = 1; e1_pos = p;
        e1_act = (p % HTOT) < HA && (p / HTOT) < VA;
        e1_cell = e1_act ? m_fb[((p / HTOT) / TH) * FW + (p % HTOT) / TW] : 8'd0;
      end
      clr = 0; fwr = 0;
      if (busWe && sel) begin
        case (off)
          0: m_ctrl = busDin[2:0];
          1: m_bg = busDin;
          2: m_cx = (busDin >= FW) ? FW - 1 : int'(busDin);
          3: m_cy = (busDin >= FH) ? FH - 1 : int'(busDin);
          4: begin
            m_fb[m_cy*FW + m_cx] = busDin;
            if (m_ctrl[1]) begin
              m_cx++;
              if (m_cx == FW) begin m_cx = 0; m_cy = (m_cy + 1) % FH; end
            end
          end
          5: clr = busDin[2];
          6: fwr = 1;
          default: ;
        endcase
      end
      m_irq = evt ? 1'b1 : (clr ? 1'b0 : m_irq);
      m_frame = fwr ? 8'd0 : (evt ? m_frame + 8'd1 : m_frame);
    end
  end

  // per-cycle compare against the model
  always @(negedge clk) begin
    if (rstN) begin
      chk("busSel", busSel, in_win(int'(busAddr)));
      chk("busDout", busDout, m_dout);
      chk("vgaColor", vgaColor, m_color);
      chk("hSync", hSync, m_hs ? SP : !SP);
      chk("vSync", vSync, m_vs ? SP : !SP);
      chk("vblankIrq", vblankIrq, m_irq && m_ctrl[2]);
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic bus_wr(input int a, input int d);
    @(posedge clk); #1;
    busWe = 1; busAddr = 6'(a); busDin = 8'(d);
    @(posedge clk); #1;
    busWe = 0;
  endtask

  task automatic bus_rd(input int a, output int d);
    @(posedge clk); #1;
    busWe = 0; busAddr = 6'(a);
    @(posedge clk); #1;
    d = int'(busDout);
  endtask

  task automatic wait_fall(input bit use_v, input int bound, output bit ok);
    bit prev, cur;
    ok = 0;
    prev = use_v ? vSync : hSync;
    for (int i = 0; i < bound; i++) begin
      @(negedge clk);
      cur = use_v ? vSync : hSync;
      if (prev && !cur) begin ok = 1; break; end
      prev = cur;
    end
  endtask

  // clocks between successive falls and clocks held low after a fall
  task automatic measure(input bit use_v, output int period, output int low);
    bit ok, cur, still_low;
    period = -1; low = 0;
    wait_fall(use_v, 2 * FRAME_CLK, ok);
    if (ok) begin
      low = 1; still_low = 1;
      for (int n = 1; n <= 2 * FRAME_CLK; n++) begin
        @(negedge clk);
        cur = use_v ? vSync : hSync;
        if (still_low && !cur) low++;
        else still_low = 0;
        if (!still_low && !cur) begin period = n; break; end
      end
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_hSync"}, hSync, 1);
    chk({tag, "_vSync"}, vSync, 1);
    chk({tag, "_vgaColor"}, vgaColor, 0);
    chk({tag, "_busDout"}, busDout, 0);
    chk({tag, "_vblankIrq"}, vblankIrq, 0);
  endtask

  initial begin
    int d, per, low, n_e0, n_07, n_00, e;
    bit ok;
    #1 rstN = 0;
    repeat (3) @(negedge clk);
    check_reset_outputs("rst_low");
    @(posedge clk); #1 rstN = 1;
    @(posedge clk); @(negedge clk);
    check_reset_outputs("rst_rel");

    // clear the framebuffer with auto-increment; cursor wraps back to (0,0)
    bus_wr(BASE + 0, 8'h02);
    for (int i = 0; i < FW * FH; i++) bus_wr(BASE + 4, 0);
    repeat (4) @(posedge clk);

    // cursor auto-increment wrap
    bus_wr(BASE + 0, 8'h03);
    bus_wr(BASE + 2, FW - 1);
    bus_wr(BASE + 3, FH - 1);
    bus_wr(BASE + 4, 8'h5A);
    bus_rd(BASE + 2, d); chk("curx_wrap", d, 0);
    bus_rd(BASE + 3, d); chk("cury_wrap", d, 0);
    bus_wr(BASE + 4, 8'h11);
    bus_rd(BASE + 2, d); chk("curx_after", d, 1);
    bus_wr(BASE + 2, 0);
    bus_rd(BASE + 4, d); chk("cell00", d, 8'h11);

    // clamping and window decode
    bus_wr(BASE + 2, 200);
    bus_rd(BASE + 2, d); chk("curx_clamp", d, FW - 1);
    bus_wr(BASE + 3, 99);
    bus_rd(BASE + 3, d); chk("cury_clamp", d, FH - 1);
    bus_rd(12, d); chk("sel12", busSel, 0); chk("dout12", d, 0);
    bus_rd(20, d); chk("sel20", busSel, 0); chk("dout20", d, 0);

    // tile + background
    bus_wr(BASE + 0, 8'h01);
    bus_wr(BASE + 1, 8'h07);
    bus_wr(BASE + 2, 1);
    bus_wr(BASE + 3, 0);
    bus_wr(BASE + 4, 8'hE0);

    // timing
    measure(0, per, low);
    chk("h_period", per, HTOT * PD); chk("h_low", low, HS * PD);
    measure(1, per, low);
    chk("frame_period", per, FRAME_CLK); chk("v_low", low, VS * HTOT * PD);

    // colour census over one whole frame
    wait_fall(1, 2 * FRAME_CLK, ok); chk("vs_fall_census", ok, 1);
    n_e0 = 0; n_07 = 0; n_00 = 0;
    for (int i = 0; i < FRAME_CLK; i++) begin
      if (vgaColor == 8'hE0) n_e0++;
      if (vgaColor == 8'h07) n_07++;
      if (vgaColor == 8'h00) n_00++;
      @(negedge clk);
    end
    chk("count_E0", n_e0, TW * TH * PD);
    chk("count_07", n_07, (HA * VA - 3 * TW * TH) * PD);
    chk("count_00", n_00, FRAME_CLK - HA * VA * PD);

    // irq and frame counter
    wait_fall(1, 2 * FRAME_CLK, ok); chk("vs_fall_irq", ok, 1);
    bus_wr(BASE + 5, 8'h04);
    bus_wr(BASE + 6, 0);
    bus_wr(BASE + 0, 8'h05);
    ok = 0;
    for (int i = 0; i < 2 * FRAME_CLK; i++) begin
      @(negedge clk);
      if (vblankIrq) begin ok = 1; break; end
    end
    chk("irq_rise", ok, 1);
    e = cyc;
    bus_rd(BASE + 6, d); chk("frame_one", d, 1);
    bus_rd(BASE + 5, d); chk("status_irq", (d >> 2) & 1, 1);
    bus_wr(BASE + 5, 8'h04);
    @(negedge clk); chk("irq_cleared", vblankIrq, 0);
    while (cyc < e + FRAME_CLK - 2) @(negedge clk);
    @(posedge clk); #1;
    busWe = 1; busAddr = 6'(BASE + 5); busDin = 8'h04;
    @(posedge clk); #1 busWe = 0;
    @(negedge clk); chk("irq_set_wins", vblankIrq, 1);
    bus_rd(BASE + 6, d); chk("frame_two", d, 2);

    // random traffic against the model
    for (int i = 0; i < 1500; i++) begin
      @(posedge clk); #1;
      busWe = ($urandom_range(0, 3) == 0);
      busAddr = 6'($urandom_range(10, 22));
      busDin = 8'($urandom);
    end
    @(posedge clk); #1 busWe = 0;

    // reset in the middle of a visible line
    bus_wr(BASE + 1, 8'h07);
    bus_wr(BASE + 0, 8'h01);
    ok = 0;
    for (int i = 0; i < 2 * FRAME_CLK; i++) begin
      @(negedge clk);
      if (vgaColor != 0) begin ok = 1; break; end
    end
    chk("visible_before_reset", ok, 1);
    #2 rstN = 0;
    #1 check_reset_outputs("rst_mid");
    @(posedge clk); #1 rstN = 1;
    repeat (200) @(posedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout actual=running expected=finished");
    $fatal(1, "timeout");
  end
endmodule
